mips_multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences the multicycle MIPS datapath (shared ALU, single instr/data memory port).

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/mips_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU op codes,
// mux select encodings and the controller state encoding.
// Pure declarations; no latency or backpressure of its own.
package mips_ctrl_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
   localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
   localparam logic [5:0] OPCODE_ADDIU = 6'b001001;
   localparam logic [5:0] OPCODE_LW    = 6'b100011;
   localparam logic [5:0] OPCODE_SW    = 6'b101011;
   localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
   localparam logic [5:0] OPCODE_J     = 6'b000010;

   // ALU operation codes, shared with the single-cycle CONTROL block
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       ALU_SRC_A_PC = 1'b0;
   localparam logic       ALU_SRC_A_RS = 1'b1;

   localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_R_EXEC    = 4'd3,
      S_R_WB      = 4'd4,
      S_IMM_EXEC  = 4'd5,
      S_IMM_WB    = 4'd6,
      S_MEM_ADDR  = 4'd7,
      S_MEM_READ  = 4'd8,
      S_MEM_WB    = 4'd9,
      S_MEM_WRITE = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12,
      S_TRAP      = 4'd13
   } state_e;

   // States that own the memory port and therefore wait on mem_ready
   function automatic logic is_mem_state(state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the multicycle controller and the datapath it steers.
// Ports: opcode/zero/mem_ready toward the controller; strobes, selects,
// trap and debug state toward the datapath. master = controller side.
interface mips_multicycle_ctrl_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               ir_write;
   logic               iord;
   logic               read_mem;
   logic               write_mem;
   logic               write_reg;
   logic               mux_write_rt_rd;
   logic               mux_reg_src_alu_mem;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_src;
   logic               trap;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, ir_write, iord, read_mem, write_mem,
             write_reg, mux_write_rt_rd, mux_reg_src_alu_mem, alu_src_a,
             alu_src_b, alu_op, pc_src, trap, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, ir_write, iord, read_mem, write_mem,
             write_reg, mux_write_rt_rd, mux_reg_src_alu_mem, alu_src_a,
             alu_src_b, alu_op, pc_src, trap, state
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has waited for mem_ready; flags the last allowed wait.
// Latency: expired_o is combinational from the count and count_en_i.
// Backpressure: none; clear_i has priority over counting.
// Ports: clk, nrst, clear_i, count_en_i, expired_o.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expired_o
);
   localparam int CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   // The count holds completed waits; when it reads MAX-1 the current
   // waiting cycle is the MAX-th one and the owner must give up.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT_MAX - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_en_i && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = count_en_i && (count_q == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath; decodes opcode once in DECODE.
// Latency: R/ADDI(U)/SW 4, LW 5, BEQ/J 3 cycles incl. FETCH with immediate mem_ready.
// Backpressure: memory states hold until mem_ready; MEM_WAIT_MAX waits without it -> TRAP.
// Ports: clk, nrst (async active-low), bus (master modport: opcode/zero/mem_ready in,
// datapath strobes, selects, trap and debug state out).
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16,
   parameter int STATE_W      = 4
) (
   input  logic                   clk,
   input  logic                   nrst,
   mips_multicycle_ctrl_if.master bus
);

   state_e     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;
   logic       in_mem_state;
   logic       wait_expired;

   assign in_mem_state = is_mem_state(state_q);

   // Count only while a memory state is stalled; any completion or any
   // non-memory state restarts the budget for the next memory access.
   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_mem_wait_timer (
      .clk        (clk),
      .nrst       (nrst),
      .clear_i    (!in_mem_state || bus.mem_ready),
      .count_en_i (in_mem_state && !bus.mem_ready),
      .expired_o  (wait_expired)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // The opcode is only trusted in DECODE; MEM_ADDR uses the latched copy.
   assign opcode_d  = (state_q == S_DECODE) ? bus.opcode : opcode_q;
   assign bus.state = STATE_W'(state_q);

   always_comb begin
      state_d                 = state_q;
      bus.pc_write            = 1'b0;
      bus.pc_write_cond       = 1'b0;
      bus.ir_write            = 1'b0;
      bus.iord                = 1'b0;
      bus.read_mem            = 1'b0;
      bus.write_mem           = 1'b0;
      bus.write_reg           = 1'b0;
      bus.mux_write_rt_rd     = 1'b0;
      bus.mux_reg_src_alu_mem = 1'b0;
      bus.alu_src_a           = ALU_SRC_A_PC;
      bus.alu_src_b           = ALU_SRC_B_RT;
      bus.alu_op              = ALUOP_ADD;
      bus.pc_src              = PC_SRC_ALU;
      bus.trap                = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            bus.read_mem  = 1'b1;
            bus.alu_src_b = ALU_SRC_B_FOUR;
            // IR and PC+4 commit only in the cycle the instruction word arrives
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_TRAP;
            end
         end

         S_DECODE: begin
            // Speculatively form the branch target into ALUOut
            bus.alu_src_b = ALU_SRC_B_IMM_SH2;
            case (bus.opcode)
               OPCODE_RTYPE:              state_d = S_R_EXEC;
               OPCODE_ADDI, OPCODE_ADDIU: state_d = S_IMM_EXEC;
               OPCODE_LW, OPCODE_SW:      state_d = S_MEM_ADDR;
               OPCODE_BEQ:                state_d = S_BRANCH;
               OPCODE_J:                  state_d = S_JUMP;
               default:                   state_d = S_TRAP;
            endcase
         end

         S_R_EXEC: begin
            bus.alu_src_a = ALU_SRC_A_RS;
            bus.alu_src_b = ALU_SRC_B_RT;
            bus.alu_op    = ALUOP_FUNCT;
            state_d       = S_R_WB;
         end

         S_R_WB: begin
            bus.write_reg           = 1'b1;
            bus.mux_write_rt_rd     = 1'b1;
            bus.mux_reg_src_alu_mem = 1'b1;
            state_d                 = S_FETCH;
         end

         S_IMM_EXEC: begin
            bus.alu_src_a = ALU_SRC_A_RS;
            bus.alu_src_b = ALU_SRC_B_IMM;
            state_d       = S_IMM_WB;
         end

         S_IMM_WB: begin
            bus.write_reg           = 1'b1;
            bus.mux_reg_src_alu_mem = 1'b1;
            state_d                 = S_FETCH;
         end

         S_MEM_ADDR: begin
            bus.alu_src_a = ALU_SRC_A_RS;
            bus.alu_src_b = ALU_SRC_B_IMM;
            state_d       = (opcode_q == OPCODE_SW) ? S_MEM_WRITE : S_MEM_READ;
         end

         S_MEM_READ: begin
            bus.read_mem = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_MEM_WB;
            end else if (wait_expired) begin
               state_d = S_TRAP;
            end
         end

         S_MEM_WB: begin
            bus.write_reg = 1'b1;
            state_d       = S_FETCH;
         end

         S_MEM_WRITE: begin
            bus.write_mem = 1'b1;
            bus.iord      = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_FETCH;
            end else if (wait_expired) begin
               state_d = S_TRAP;
            end
         end

         S_BRANCH: begin
            bus.alu_src_a     = ALU_SRC_A_RS;
            bus.alu_src_b     = ALU_SRC_B_RT;
            bus.alu_op        = ALUOP_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_src        = PC_SRC_ALUOUT;
            state_d           = S_FETCH;
         end

         S_JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_SRC_JUMP;
            state_d      = S_FETCH;
         end

         S_TRAP: begin
            bus.trap = 1'b1;
         end

         // Unused encodings are treated as a fault
         default: state_d = S_TRAP;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-instruction phase model builds an
// expected per-cycle (state, outputs) queue, which is then played against the DUT.
module tb_mips_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   localparam int WMAX = 16;

   logic clk  = 1'b0;
   logic nrst = 1'b0;

   mips_multicycle_ctrl_if #(.STATE_W(4)) bus ();

   mips_multicycle_ctrl #(
      .MEM_WAIT_MAX (WMAX),
      .STATE_W      (4)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      state_e     st;
      logic       mr;
      logic       z;
      logic [5:0] op;
   } cyc_t;

   cyc_t        exp_q[$];
   logic [3:0]  obs_st[$];
   logic [16:0] obs_out[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // {pc_write, pc_write_cond, ir_write, iord, read_mem, write_mem, write_reg,
   //  rt_rd, src_alu_mem, alu_src_a, alu_src_b[2], alu_op[2], pc_src[2], trap}
   function automatic logic [16:0] exp_out(state_e s, logic mr);
      logic pw, pwc, irw, iord, rd, wr, wreg, rtrd, src, a, trap;
      logic [1:0] b, op, ps;
      pw = 0; pwc = 0; irw = 0; iord = 0; rd = 0; wr = 0; wreg = 0;
      rtrd = 0; src = 0; a = 0; trap = 0; b = 2'b00; op = 2'b00; ps = 2'b00;
      case (s)
         S_FETCH:     begin rd = 1; b = 2'b01; if (mr) begin irw = 1; pw = 1; end end
         S_DECODE:    b = 2'b11;
         S_R_EXEC:    begin a = 1; op = 2'b10; end
         S_R_WB:      begin wreg = 1; rtrd = 1; src = 1; end
         S_IMM_EXEC:  begin a = 1; b = 2'b10; end
         S_MEM_ADDR:  begin a = 1; b = 2'b10; end
         S_IMM_WB:    begin wreg = 1; src = 1; end
         S_MEM_READ:  begin rd = 1; iord = 1; end
         S_MEM_WB:    wreg = 1;
         S_MEM_WRITE: begin wr = 1; iord = 1; end
         S_BRANCH:    begin a = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
         S_JUMP:      begin pw = 1; ps = 2'b10; end
         S_TRAP:      trap = 1;
         default:     ;
      endcase
      return {pw, pwc, irw, iord, rd, wr, wreg, rtrd, src, a, b, op, ps, trap};
   endfunction

   function automatic logic [16:0] sample();
      return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.read_mem,
              bus.write_mem, bus.write_reg, bus.mux_write_rt_rd, bus.mux_reg_src_alu_mem,
              bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.trap};
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   // ---------------- reference model: expected cycle queue ----------------
   task automatic push(input state_e s, input logic mr, input logic [5:0] op);
      cyc_t c;
      c.st = s; c.mr = mr; c.z = 1'($urandom); c.op = op;
      exp_q.push_back(c);
   endtask

   // A memory phase waiting w cycles; w >= WMAX means it never completes in budget.
   task automatic push_wait(input state_e s, input int w, output bit timed_out);
      int n;
      n = (w >= WMAX) ? WMAX : w;
      for (int i = 0; i < n; i++) push(s, 1'b0, rnd_op());
      timed_out = (w >= WMAX);
      if (!timed_out) push(s, 1'b1, rnd_op());
   endtask

   task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
      bit tmo;
      push_wait(S_FETCH, fw, tmo);
      if (tmo) begin push(S_TRAP, 1'($urandom), rnd_op()); return; end
      push(S_DECODE, 1'($urandom), op);
      case (op)
         6'b000000: begin push(S_R_EXEC, 1'($urandom), rnd_op()); push(S_R_WB, 1'($urandom), rnd_op()); end
         6'b001000, 6'b001001: begin
            push(S_IMM_EXEC, 1'($urandom), rnd_op()); push(S_IMM_WB, 1'($urandom), rnd_op());
         end
         6'b100011: begin
            push(S_MEM_ADDR, 1'($urandom), rnd_op());
            push_wait(S_MEM_READ, mw, tmo);
            if (tmo) push(S_TRAP, 1'($urandom), rnd_op());
            else     push(S_MEM_WB, 1'($urandom), rnd_op());
         end
         6'b101011: begin
            push(S_MEM_ADDR, 1'($urandom), rnd_op());
            push_wait(S_MEM_WRITE, mw, tmo);
            if (tmo) push(S_TRAP, 1'($urandom), rnd_op());
         end
         6'b000100: push(S_BRANCH, 1'($urandom), rnd_op());
         6'b000010: push(S_JUMP, 1'($urandom), rnd_op());
         default:   push(S_TRAP, 1'($urandom), rnd_op());
      endcase
   endtask

   task automatic start_queue();
      exp_q.delete();
      push(S_IDLE, 1'($urandom), rnd_op());
   endtask

   // ---------------- stimulus plumbing ----------------
   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.opcode = '0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   // Starts right after a negedge; drives each cycle's inputs, samples 1ns later.
   task automatic play();
      obs_st.delete(); obs_out.delete();
      foreach (exp_q[i]) begin
         bus.opcode    = exp_q[i].op;
         bus.mem_ready = exp_q[i].mr;
         bus.zero      = exp_q[i].z;
         #1;
         obs_st.push_back(bus.state);
         obs_out.push_back(sample());
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // Reach a stalled MEM_WRITE
      do_reset();
      start_queue();
      push(S_FETCH, 1'b1, rnd_op());
      push(S_DECODE, 1'b0, 6'b101011);
      push(S_MEM_ADDR, 1'b0, rnd_op());
      for (int i = 0; i < 3; i++) push(S_MEM_WRITE, 1'b0, rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL reset_prep cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
      bus.mem_ready = 1'b0;
      #1;
      n_tests++;
      if (bus.write_mem !== 1'b1 || bus.state !== S_MEM_WRITE) begin
         n_fail++;
         $display("FAIL reset_pre_write: write_mem=%b state=%0d expected 1 / %0d",
                  bus.write_mem, bus.state, S_MEM_WRITE);
      end
      // Asynchronous reset mid-cycle
      #1 nrst = 1'b0;
      #1;
      n_tests++;
      if (bus.state !== S_IDLE || sample() !== 17'h0) begin
         n_fail++;
         $display("FAIL reset_async: state=%0d out=%h expected %0d / 0", bus.state, sample(), S_IDLE);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.state !== S_IDLE || bus.trap !== 1'b0 || bus.write_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: state=%0d trap=%b write_mem=%b expected %0d/0/0",
                  bus.state, bus.trap, bus.write_mem, S_IDLE);
      end
      @(negedge clk);
      nrst = 1'b1;
      // Release -> FETCH next edge; wait budget starts fresh (15 waits + ready survives)
      start_queue();
      add_instr(6'b000000, WMAX - 1, 0);
      push(S_FETCH, 1'b0, rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL reset_release cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   task automatic test_rtype();
      int wreg_cnt;
      do_reset();
      start_queue();
      add_instr(6'b000000, 0, 0);
      push(S_FETCH, 1'b1, rnd_op());
      play();
      wreg_cnt = 0;
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL rtype cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
         if (obs_out[i][10]) wreg_cnt++;
      end
      n_tests++;
      if (wreg_cnt !== 1 || obs_st[5] !== S_FETCH) begin
         n_fail++;
         $display("FAIL rtype_latency: write_reg cycles=%0d state@5=%0d expected 1 / %0d",
                  wreg_cnt, obs_st[5], S_FETCH);
      end
   endtask

   task automatic test_lw_wait();
      do_reset();
      start_queue();
      add_instr(6'b100011, 0, 3);
      push(S_FETCH, 1'b1, rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL lw_wait cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   task automatic test_beq();
      int nb;
      do_reset();
      start_queue();
      add_instr(6'b000100, 0, 0);
      add_instr(6'b000100, 0, 0);
      push(S_FETCH, 1'b1, rnd_op());
      nb = 0;
      foreach (exp_q[i]) if (exp_q[i].st == S_BRANCH) begin exp_q[i].z = (nb == 0); nb++; end
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL beq cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      start_queue();
      add_instr(6'b111111, 0, 0);
      for (int i = 0; i < 100; i++) push(S_TRAP, 1'($urandom), rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL illegal cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   task automatic test_timeouts();
      // FETCH never ready -> TRAP after WMAX waits
      do_reset();
      start_queue();
      add_instr(6'b000000, WMAX, 0);
      for (int i = 0; i < 5; i++) push(S_TRAP, 1'($urandom), rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL fetch_timeout cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
      // Ready on the last allowed cycle wins; then a SW that times out
      do_reset();
      start_queue();
      add_instr(6'b000010, WMAX - 1, 0);
      add_instr(6'b101011, 0, WMAX);
      for (int i = 0; i < 3; i++) push(S_TRAP, 1'($urandom), rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL ready_last cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] legal [7];
      legal = '{6'b000000, 6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
      do_reset();
      start_queue();
      for (int k = 0; k < 40; k++) begin
         int fw, mw;
         fw = ($urandom_range(0, 9) == 0) ? WMAX - 1 : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 9) == 0) ? WMAX - 1 : int'($urandom_range(0, 3));
         add_instr(legal[$urandom_range(0, 6)], fw, mw);
      end
      push(S_FETCH, 1'b0, rnd_op());
      play();
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_st[i] !== exp_q[i].st || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].mr)) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d: state=%0d out=%h expected state=%0d out=%h",
                     i, obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].mr));
         end
      end
   endtask

   initial begin
      bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_timeouts();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
